// File: rtl/controle_valvulas.sv
// Valve sequencer for the drip (vg) and sprinkler (va) valves sharing one pump:
// round-robin grant, minimum/maximum open time, fixed settling pause, forced close on alarm/disable.
module controle_valvulas #(
  parameter int MIN_ON = 8,
  parameter int MAX_ON = 64,
  parameter int PAUSE  = 16,
  parameter int CW     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       req_g,
  input  logic       req_a,
  input  logic       alin,
  output logic       vg,
  output logic       va,
  output logic       bomba,
  output logic       timeout,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_OPEN_G = 2'b01,
    ST_OPEN_A = 2'b10,
    ST_PAUSE  = 2'b11
  } state_t;

  localparam logic [CW-1:0] MIN_LAST   = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] MAX_LAST   = CW'(MAX_ON - 1);
  localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          prio, prio_next;
  logic          timeout_next;
  logic          granted_req;

  // Requests are level signals sampled only in IDLE; there is no acknowledge,
  // a requester sees its grant as its valve output going high one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      prio    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_next;
      prio    <= prio_next;
      timeout <= timeout_next;
      if (state_next != state)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    prio_next    = prio;
    timeout_next = 1'b0;
    granted_req  = (state == ST_OPEN_G) ? req_g : req_a;
    case (state)
      ST_IDLE: begin
        if (en && !alin) begin
          // Drip wins when alone, or when both ask and it is drip's turn.
          if (req_g && (!req_a || !prio)) begin
            state_next = ST_OPEN_G;
            prio_next  = 1'b1;
          end else if (req_a) begin
            state_next = ST_OPEN_A;
            prio_next  = 1'b0;
          end
        end
      end
      ST_OPEN_G, ST_OPEN_A: begin
        if (!en || alin) begin
          state_next = ST_PAUSE;
        end else if (cnt == MAX_LAST) begin
          state_next   = ST_PAUSE;
          timeout_next = 1'b1;
        end else if (cnt >= MIN_LAST && !granted_req) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (cnt == PAUSE_LAST)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign vg     = (state == ST_OPEN_G);
  assign va     = (state == ST_OPEN_A);
  assign bomba  = vg | va;
  assign estado = state;

endmodule

// File: tb/tb_controle_valvulas.sv
// Randomized bench for controle_valvulas: a duration-based behavioural model feeds an
// expected queue, and a monitor compares every cycle's outputs against it.
module tb_controle_valvulas;

  localparam int MIN_ON = 4;
  localparam int MAX_ON = 10;
  localparam int PAUSE  = 3;
  localparam int CW     = 8;
  localparam int W      = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, req_g = 1'b0, req_a = 1'b0, alin = 1'b0;
  logic       vg, va, bomba, timeout;
  logic [1:0] estado;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  controle_valvulas #(.MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .PAUSE(PAUSE), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_g(req_g), .req_a(req_a), .alin(alin),
    .vg(vg), .va(va), .bomba(bomba), .timeout(timeout), .estado(estado)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: mode 0 idle, 1 drip open, 2 sprinkler open, 3 pause;
  // run = how many cycles the current open/pause period has lasted so far
  int m_mode = 0;
  int m_run  = 0;
  bit m_prio = 1'b0;
  bit m_to   = 1'b0;

  function automatic logic [W-1:0] model_vec();
    logic g, a;
    g = (m_mode == 1);
    a = (m_mode == 2);
    return {m_to, 2'(m_mode), g | a, a, g};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_prio = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_edge();
    bit r;
    m_to = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: if (en && !alin && (req_g || req_a)) begin
        if (req_g && req_a) m_mode = m_prio ? 2 : 1;
        else                m_mode = req_g ? 1 : 2;
        m_prio = (m_mode == 1);
        m_run  = 1;
      end
      1, 2: begin
        r = (m_mode == 1) ? req_g : req_a;
        if (!en || alin) begin
          m_mode = 3; m_run = 1;
        end else if (m_run == MAX_ON) begin
          m_mode = 3; m_run = 1; m_to = 1'b1;
        end else if (m_run >= MIN_ON && !r) begin
          m_mode = 3; m_run = 1;
        end else begin
          m_run++;
        end
      end
      default: if (m_run == PAUSE) begin
        m_mode = 0; m_run = 0;
      end else begin
        m_run++;
      end
    endcase
  endtask

  // driver: apply inputs away from the edge, then advance the model at the edge
  task automatic cyc(input logic r, input logic e, input logic g, input logic a, input logic al);
    @(negedge clk);
    rst_n = r; en = e; req_g = g; req_a = a; alin = al;
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_vec());
  endtask

  task automatic run(input int n, input logic e, input logic g, input logic a, input logic al);
    for (int i = 0; i < n; i++) cyc(1'b1, e, g, a, al);
  endtask

  task automatic check_now(input string name, input logic [W-1:0] want);
    logic [W-1:0] got;
    got = {timeout, estado, bomba, va, vg};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, want);
    end
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check_now("outputs", exp_q.pop_front());
  end

  initial begin
    // 1. reset with random inputs, checked asynchronously too
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    #2 check_now("reset_hold", '0);
    run(3, 1'b1, 1'b0, 1'b0, 1'b0);

    // 2. one-cycle drip pulse: held to MIN_ON, then pause
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run(10, 1'b1, 1'b0, 1'b0, 1'b0);

    // 3. drip held: MAX_ON timeout, pause, regrant
    run(30, 1'b1, 1'b1, 1'b0, 1'b0);
    run(PAUSE + MAX_ON + 2, 1'b1, 1'b0, 1'b0, 1'b0);

    // 4. both held from reset: alternating grants
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(3 * (MAX_ON + PAUSE + 1) + 2, 1'b1, 1'b1, 1'b1, 1'b0);
    run(MAX_ON + PAUSE + 2, 1'b1, 1'b0, 1'b0, 1'b0);

    // 5. alarm on second cycle of sprinkler grant, alarm kept through the pause
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    run(PAUSE + 4, 1'b1, 1'b1, 1'b1, 1'b1);
    run(PAUSE + 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6. async reset mid drip grant, then both requests: drip must win
    run(2, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_now("async_reset", '0);
    model_reset();
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run(MAX_ON + 4, 1'b1, 1'b1, 1'b1, 1'b0);
    run(MAX_ON + PAUSE + 2, 1'b1, 1'b0, 1'b0, 1'b0);

    // random traffic with sticky requests, occasional disable and alarm
    for (int i = 0; i < 600; i++) begin
      logic g, a;
      g = ($urandom_range(0, 5) == 0) ? ~req_g : req_g;
      a = ($urandom_range(0, 5) == 0) ? ~req_a : req_a;
      cyc(1'b1, 1'($urandom_range(0, 24) != 0), g, a, 1'($urandom_range(0, 29) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
